screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
Top-level display sequencer for the piano-keys game. It owns the screen flow: home, playing, paused and game-over. It arbitrates three pixel sources (home drawer, game controller, game-over drawer) onto a single registered VGA plot bus. Before every screen change it can run a parametrised full-screen background clear, and it adds a pause mode driven by the start button.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COL_W, 3, colour width
SCREEN_W, 160, clear-region width in pixels
SCREEN_H, 120, clear-region height in pixels
BG_COL, 0, colour used by the clear phase
CLEAR_EN, 1, 1 = run the clear phase before every screen draw; 0 = skip it

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  synchronous, active-low reset
start  in  1  start/pause button level, already synchronised
game_over  in  1  level from the game controller
hs_x/hs_y/hs_col  in  X_W/Y_W/COL_W  home-screen drawer pixel
hs_plot  in  1  home drawer pixel valid
hs_done  in  1  home drawer finished (1-cycle pulse)
gc_x/gc_y/gc_col  in  X_W/Y_W/COL_W  game controller pixel
gc_plot  in  1  game pixel valid
go_x/go_y/go_col  in  X_W/Y_W/COL_W  game-over drawer pixel
go_plot  in  1  game-over pixel valid
go_done  in  1  game-over drawer finished (1-cycle pulse)
draw_home  out  1  high while the home drawer must run
draw_over  out  1  high while the game-over drawer must run
game_en  out  1  game controller run enable
game_restart  out  1  1-cycle pulse: game controller must reinitialise
x_out/y_out/col_out  out  X_W/Y_W/COL_W  registered pixel
plot  out  1  registered pixel write enable
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset: synchronous. Every output is 0 at reset, and the clear counters are 0.
  - State after reset is S_CLEAR with target=HOME; if CLEAR_EN=0 it is S_DRAW_HOME.
  - Reset asserted mid-clear or mid-draw abandons the operation and restarts from the reset state.
- start_evt: 1-cycle pulse on a start release, i.e. start_q=1 and start=0, where start_q is a registered copy of start (reset 0).
  - Every transition keyed on start uses start_evt only, so holding the button never auto-repeats.
- States: S_CLEAR, S_DRAW_HOME, S_HOME, S_PLAY, S_PAUSE, S_DRAW_OVER, S_OVER.
- S_CLEAR:
  - Raster-scans cx 0..SCREEN_W-1 (inner) and cy 0..SCREEN_H-1 (outer), one pixel per cycle, colour BG_COL, plot=1.
  - Takes exactly SCREEN_W*SCREEN_H cycles.
  - After the pixel (SCREEN_W-1, SCREEN_H-1) it moves to the stored target draw state; for target PLAY it goes to S_PLAY.
  - Counters clear to 0 on exit.
- S_DRAW_HOME: draw_home=1 and the home pixel stream is selected. On hs_done go to S_HOME. A pixel plotted in the same cycle as hs_done is still forwarded.
- S_HOME: plot=0. On start_evt go to clear with target PLAY.
- S_PLAY: game_en=1 and the game pixel stream is selected.
  - game_over=1 → clear with target OVER.
  - Otherwise start_evt → S_PAUSE.
  - If both occur in the same cycle, game_over wins.
- S_PAUSE: game_en=0, plot=0, game_over ignored. On start_evt return to S_PLAY with no clear and no restart.
- S_DRAW_OVER: draw_over=1 and the game-over stream is selected. On go_done go to S_OVER.
- S_OVER: plot=0. On start_evt go to clear with target PLAY.
- game_restart: pulses for 1 cycle on the cycle the FSM enters S_PLAY from S_CLEAR, or directly from S_HOME/S_OVER when CLEAR_EN=0. It never pulses on a resume from S_PAUSE.
- Output pipeline:
  - Mux select is combinational from the state.
  - x_out/y_out/col_out/plot are registered, so latency is 1 cycle from source input to output.
  - plot is the selected source's plot gated by the state; it is 0 in S_HOME, S_PAUSE, S_OVER and in draw states where the source's plot is low.
- Unused source inputs are ignored, e.g. hs_done outside S_DRAW_HOME.
- Width rule: the clear counters are X_W/Y_W wide; SCREEN_W ≤ 2^X_W and SCREEN_H ≤ 2^Y_W.
- Illegal state encodings recover to S_CLEAR with target HOME.

Decomposition:
- Package screen_seq_pkg holds:
  - the state localparams and their 3-bit encodings;
  - the target encodings HOME/PLAY/OVER;
  - the source-select encodings.
- One sub-module, screen_clear_counter: the raster counter, with inputs en/clr and outputs cx/cy/last.
- The FSM, start-edge detect and output mux/register stay in screen_sequencer.

Test Plan:
- Reset → clear sweep (SCREEN_W=4, SCREEN_H=3):
  - Release reset; expect 12 consecutive plot=1 cycles with col_out=BG_COL, x/y sequence (0,0),(1,0)…(3,2).
  - Then draw_home=1 and state_o=S_DRAW_HOME.
- Home draw and start:
  - Feed hs_plot with (5,6,col 3) for 3 cycles, pulsing hs_done on the 3rd; expect 3 plotted pixels, each 1 cycle later.
  - Hold start high 10 cycles: no transition. Release: clear runs, then S_PLAY with a 1-cycle game_restart and game_en=1.
- Pause/resume:
  - In S_PLAY, press-release start → game_en=0 and plot=0 while gc_plot=1.
  - Press-release again → game_en=1, no clear, no game_restart.
- Game-over priority: in S_PLAY raise game_over and start_evt in the same cycle → clear (target OVER) then S_DRAW_OVER with draw_over=1. No pause occurs.
- Restart from game over: go_done, then start_evt → clear, then game_restart pulse and S_PLAY.
- CLEAR_EN=0 and mid-operation reset:
  - CLEAR_EN=0: reset goes directly to S_DRAW_HOME with no clear plots.
  - CLEAR_EN=1: assert resetn=0 at clear pixel 7 → all outputs 0 next cycle; clear restarts at (0,0).

Source files
------------

// File: rtl/screen_sequencer_pkg.sv
// Shared encodings for the screen sequencer: FSM states, clear targets and pixel-source selects.
// Pure definitions with no timing or flow control of their own.
package screen_seq_pkg;

  typedef enum logic [2:0] {
    S_CLEAR     = 3'd0,
    S_DRAW_HOME = 3'd1,
    S_HOME      = 3'd2,
    S_PLAY      = 3'd3,
    S_PAUSE     = 3'd4,
    S_DRAW_OVER = 3'd5,
    S_OVER      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    TGT_HOME = 2'd0,
    TGT_PLAY = 2'd1,
    TGT_OVER = 2'd2
  } target_t;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_CLEAR = 3'd1,
    SRC_HOME  = 3'd2,
    SRC_GAME  = 3'd3,
    SRC_OVER  = 3'd4
  } src_t;

  // Idle screens and illegal encodings select no source, so plot stays low there.
  function automatic src_t state_src(input state_t s);
    case (s)
      S_CLEAR:     return SRC_CLEAR;
      S_DRAW_HOME: return SRC_HOME;
      S_PLAY:      return SRC_GAME;
      S_DRAW_OVER: return SRC_OVER;
      default:     return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Control and pixel bus between the screen sequencer and its drawers, game controller and VGA plotter.
// Plain level/pulse signals with no handshake; master is the sequencer side.
interface screen_sequencer_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3
);
  logic             start;
  logic             game_over;
  logic [X_W-1:0]   hs_x, gc_x, go_x;
  logic [Y_W-1:0]   hs_y, gc_y, go_y;
  logic [COL_W-1:0] hs_col, gc_col, go_col;
  logic             hs_plot, hs_done;
  logic             gc_plot;
  logic             go_plot, go_done;

  logic             draw_home;
  logic             draw_over;
  logic             game_en;
  logic             game_restart;
  logic [X_W-1:0]   x_out;
  logic [Y_W-1:0]   y_out;
  logic [COL_W-1:0] col_out;
  logic             plot;
  logic [2:0]       state_o;

  modport master (
    input  start, game_over,
    input  hs_x, hs_y, hs_col, hs_plot, hs_done,
    input  gc_x, gc_y, gc_col, gc_plot,
    input  go_x, go_y, go_col, go_plot, go_done,
    output draw_home, draw_over, game_en, game_restart,
    output x_out, y_out, col_out, plot, state_o
  );

  modport slave (
    output start, game_over,
    output hs_x, hs_y, hs_col, hs_plot, hs_done,
    output gc_x, gc_y, gc_col, gc_plot,
    output go_x, go_y, go_col, go_plot, go_done,
    input  draw_home, draw_over, game_en, game_restart,
    input  x_out, y_out, col_out, plot, state_o
  );
endinterface

// File: rtl/screen_sequencer_clear_counter.sv
// Raster counter for the background clear: x inner, y outer, one pixel per enabled cycle.
// last is combinational on the final pixel; no backpressure, clr forces both counters to 0.
module screen_clear_counter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           en,
  input  logic           clr,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign last = (cx == X_LAST) && (cy == Y_LAST);
endmodule

// File: rtl/screen_sequencer.sv
// Screen-flow FSM (home/play/pause/game-over) arbitrating three pixel sources plus a background clear.
// Pixel bus is registered: 1-cycle latency from source to x_out/plot; no backpressure.
module screen_sequencer
  import screen_seq_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COL_W    = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int BG_COL   = 0,
  parameter int CLEAR_EN = 1
) (
  input logic                clk,
  input logic                resetn,
  screen_sequencer_if.master bus
);
  localparam state_t RST_STATE = (CLEAR_EN != 0) ? S_CLEAR : S_DRAW_HOME;

  state_t           r_state;
  target_t          r_target;
  logic             r_start_q;
  logic             r_draw_home, r_draw_over, r_game_en, r_game_restart;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [COL_W-1:0] r_col;
  logic             r_plot;

  logic [X_W-1:0]   w_cx, w_x;
  logic [Y_W-1:0]   w_cy, w_y;
  logic [COL_W-1:0] w_col;
  logic             w_plot, w_last, w_start_evt;

  // Act on release so a held button never repeats.
  assign w_start_evt = r_start_q && !bus.start;

  screen_clear_counter #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) u_clear (
    .clk(clk), .resetn(resetn),
    .en(r_state == S_CLEAR), .clr(r_state != S_CLEAR),
    .cx(w_cx), .cy(w_cy), .last(w_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= RST_STATE;
      r_target       <= TGT_HOME;
      r_start_q      <= 1'b0;
      r_draw_home    <= 1'b0;
      r_draw_over    <= 1'b0;
      r_game_en      <= 1'b0;
      r_game_restart <= 1'b0;
    end else begin
      r_start_q      <= bus.start;
      r_game_restart <= 1'b0;
      case (r_state)
        S_CLEAR: if (w_last) begin
          case (r_target)
            TGT_PLAY: begin r_state <= S_PLAY; r_game_en <= 1'b1; r_game_restart <= 1'b1; end
            TGT_OVER: begin r_state <= S_DRAW_OVER; r_draw_over <= 1'b1; end
            default:  begin r_state <= S_DRAW_HOME; r_draw_home <= 1'b1; end
          endcase
        end
        S_DRAW_HOME: begin
          r_draw_home <= !bus.hs_done;
          if (bus.hs_done) r_state <= S_HOME;
        end
        S_HOME, S_OVER: if (w_start_evt) begin
          if (CLEAR_EN != 0) begin
            r_state  <= S_CLEAR;
            r_target <= TGT_PLAY;
          end else begin
            r_state        <= S_PLAY;
            r_game_en      <= 1'b1;
            r_game_restart <= 1'b1;
          end
        end
        S_PLAY: begin
          if (bus.game_over) begin
            r_game_en <= 1'b0;
            if (CLEAR_EN != 0) begin
              r_state  <= S_CLEAR;
              r_target <= TGT_OVER;
            end else begin
              r_state     <= S_DRAW_OVER;
              r_draw_over <= 1'b1;
            end
          end else if (w_start_evt) begin
            r_state   <= S_PAUSE;
            r_game_en <= 1'b0;
          end else begin
            r_game_en <= 1'b1;
          end
        end
        S_PAUSE: if (w_start_evt) begin
          r_state   <= S_PLAY;
          r_game_en <= 1'b1;
        end
        S_DRAW_OVER: begin
          r_draw_over <= !bus.go_done;
          if (bus.go_done) r_state <= S_OVER;
        end
        default: begin
          r_state     <= S_CLEAR;
          r_target    <= TGT_HOME;
          r_draw_home <= 1'b0;
          r_draw_over <= 1'b0;
          r_game_en   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_x    = '0;
    w_y    = '0;
    w_col  = '0;
    w_plot = 1'b0;
    case (state_src(r_state))
      SRC_CLEAR: begin w_x = w_cx; w_y = w_cy; w_col = COL_W'(BG_COL); w_plot = 1'b1; end
      SRC_HOME:  begin w_x = bus.hs_x; w_y = bus.hs_y; w_col = bus.hs_col; w_plot = bus.hs_plot; end
      SRC_GAME:  begin w_x = bus.gc_x; w_y = bus.gc_y; w_col = bus.gc_col; w_plot = bus.gc_plot; end
      SRC_OVER:  begin w_x = bus.go_x; w_y = bus.go_y; w_col = bus.go_col; w_plot = bus.go_plot; end
      default:   begin end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_col  <= '0;
      r_plot <= 1'b0;
    end else begin
      r_x    <= w_x;
      r_y    <= w_y;
      r_col  <= w_col;
      r_plot <= w_plot;
    end
  end

  assign bus.draw_home    = r_draw_home;
  assign bus.draw_over    = r_draw_over;
  assign bus.game_en      = r_game_en;
  assign bus.game_restart = r_game_restart;
  assign bus.x_out        = r_x;
  assign bus.y_out        = r_y;
  assign bus.col_out      = r_col;
  assign bus.plot         = r_plot;
  assign bus.state_o      = r_state;
endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench: a 4x3 clear-enabled instance walks the full screen flow; a second
// instance with the clear disabled checks the direct transitions.
module tb_screen_sequencer;
  logic clk = 1'b0;
  logic resetn, resetn_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  screen_sequencer_if #(.X_W(8), .Y_W(7), .COL_W(3)) bus_a ();
  screen_sequencer_if #(.X_W(8), .Y_W(7), .COL_W(3)) bus_b ();

  screen_sequencer #(.X_W(8), .Y_W(7), .COL_W(3), .SCREEN_W(4), .SCREEN_H(3),
                     .BG_COL(5), .CLEAR_EN(1)) dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  screen_sequencer #(.X_W(8), .Y_W(7), .COL_W(3), .SCREEN_W(4), .SCREEN_H(3),
                     .BG_COL(5), .CLEAR_EN(0)) dut_b (.clk(clk), .resetn(resetn_b), .bus(bus_b));

  typedef struct {
    logic       st, gov, hsp, hsd, gcp, gop, god;
    logic [2:0] e_state;
    logic       e_plot;
    logic [7:0] e_x;
    logic       e_dh, e_do, e_ge, e_gr;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic st, gov, hsp, hsd, gcp, gop, god,
                              input logic [2:0] es, input logic ep, input logic [7:0] ex,
                              input logic edh, edo, ege, egr);
    vec_t v;
    v.st = st; v.gov = gov; v.hsp = hsp; v.hsd = hsd; v.gcp = gcp; v.gop = gop; v.god = god;
    v.e_state = es; v.e_plot = ep; v.e_x = ex;
    v.e_dh = edh; v.e_do = edo; v.e_ge = ege; v.e_gr = egr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.start = 0; bus_a.game_over = 0;
    bus_a.hs_plot = 0; bus_a.hs_done = 0; bus_a.gc_plot = 0;
    bus_a.go_plot = 0; bus_a.go_done = 0;
  endtask

  task automatic apply_vec(input int i);
    bus_a.start = vecs[i].st;   bus_a.game_over = vecs[i].gov;
    bus_a.hs_plot = vecs[i].hsp; bus_a.hs_done = vecs[i].hsd;
    bus_a.gc_plot = vecs[i].gcp;
    bus_a.go_plot = vecs[i].gop; bus_a.go_done = vecs[i].god;
    tick();
    chk($sformatf("vec%0d state", i), bus_a.state_o, vecs[i].e_state);
    chk($sformatf("vec%0d plot", i), bus_a.plot, vecs[i].e_plot);
    if (vecs[i].e_plot) chk($sformatf("vec%0d x", i), bus_a.x_out, vecs[i].e_x);
    chk($sformatf("vec%0d draw_home", i), bus_a.draw_home, vecs[i].e_dh);
    chk($sformatf("vec%0d draw_over", i), bus_a.draw_over, vecs[i].e_do);
    chk($sformatf("vec%0d game_en", i), bus_a.game_en, vecs[i].e_ge);
    chk($sformatf("vec%0d game_restart", i), bus_a.game_restart, vecs[i].e_gr);
  endtask

  // Twelve clear pixels in raster order, then the target state and its outputs.
  task automatic check_clear(input string nm, input logic [2:0] es,
                             input logic edh, edo, ege, egr);
    idle_a();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("%s pix%0d", nm, i),
          {bus_a.plot, bus_a.col_out, bus_a.y_out, bus_a.x_out},
          {1'b1, 3'd5, 7'(i / 4), 8'(i % 4)});
    end
    chk({nm, " state"}, bus_a.state_o, es);
    chk({nm, " draw_home"}, bus_a.draw_home, edh);
    chk({nm, " draw_over"}, bus_a.draw_over, edo);
    chk({nm, " game_en"}, bus_a.game_en, ege);
    chk({nm, " game_restart"}, bus_a.game_restart, egr);
  endtask

  initial begin
    // st gov hsp hsd gcp gop god | state plot x | dh do ge gr
    vecs[0]  = mk(0,0,1,0,0,0,0, 3'd1,1,8'd5,  1,0,0,0);
    vecs[1]  = mk(0,0,1,0,0,0,0, 3'd1,1,8'd5,  1,0,0,0);
    vecs[2]  = mk(0,0,1,1,0,0,0, 3'd2,1,8'd5,  0,0,0,0);
    vecs[3]  = mk(0,0,0,0,0,0,0, 3'd2,0,8'd0,  0,0,0,0);
    vecs[4]  = mk(0,0,1,1,0,0,0, 3'd2,0,8'd0,  0,0,0,0);
    vecs[5]  = mk(0,0,0,0,1,0,0, 3'd3,1,8'd10, 0,0,1,0);
    vecs[6]  = mk(1,0,0,0,1,0,0, 3'd3,1,8'd10, 0,0,1,0);
    vecs[7]  = mk(0,0,0,0,1,0,0, 3'd4,1,8'd10, 0,0,0,0);
    vecs[8]  = mk(0,0,0,0,1,0,0, 3'd4,0,8'd0,  0,0,0,0);
    vecs[9]  = mk(0,1,0,0,1,0,0, 3'd4,0,8'd0,  0,0,0,0);
    vecs[10] = mk(1,0,0,0,1,0,0, 3'd4,0,8'd0,  0,0,0,0);
    vecs[11] = mk(0,0,0,0,1,0,0, 3'd3,0,8'd0,  0,0,1,0);
    vecs[12] = mk(0,0,0,0,1,0,0, 3'd3,1,8'd10, 0,0,1,0);
    vecs[13] = mk(1,0,0,0,1,0,0, 3'd3,1,8'd10, 0,0,1,0);
    vecs[14] = mk(0,1,0,0,1,0,0, 3'd0,1,8'd10, 0,0,0,0);
    vecs[15] = mk(0,0,0,0,0,1,0, 3'd5,1,8'd30, 0,1,0,0);
    vecs[16] = mk(0,0,0,0,0,1,1, 3'd6,1,8'd30, 0,0,0,0);
    vecs[17] = mk(0,0,0,0,0,0,0, 3'd6,0,8'd0,  0,0,0,0);
    vecs[18] = mk(1,0,0,0,0,0,0, 3'd6,0,8'd0,  0,0,0,0);
    vecs[19] = mk(0,0,0,0,0,0,0, 3'd0,0,8'd0,  0,0,0,0);

    bus_a.hs_x = 8'd5;  bus_a.hs_y = 7'd6;  bus_a.hs_col = 3'd3;
    bus_a.gc_x = 8'd10; bus_a.gc_y = 7'd20; bus_a.gc_col = 3'd4;
    bus_a.go_x = 8'd30; bus_a.go_y = 7'd40; bus_a.go_col = 3'd6;
    bus_b.hs_x = 8'd5;  bus_b.hs_y = 7'd6;  bus_b.hs_col = 3'd3;
    bus_b.gc_x = 8'd10; bus_b.gc_y = 7'd20; bus_b.gc_col = 3'd4;
    bus_b.go_x = 8'd30; bus_b.go_y = 7'd40; bus_b.go_col = 3'd6;
    bus_b.start = 0; bus_b.game_over = 0; bus_b.hs_plot = 0; bus_b.hs_done = 0;
    bus_b.gc_plot = 0; bus_b.go_plot = 0; bus_b.go_done = 0;
    idle_a();
    resetn = 0; resetn_b = 0;
    tick(); tick();
    chk("rst plot", bus_a.plot, 0);
    chk("rst xycol", {bus_a.x_out, bus_a.y_out, bus_a.col_out}, 0);
    chk("rst flags", {bus_a.draw_home, bus_a.draw_over, bus_a.game_en, bus_a.game_restart}, 0);
    chk("rst state", bus_a.state_o, 0);

    resetn = 1;
    check_clear("clr_home", 3'd1, 1, 0, 0, 0);
    for (int i = 0; i <= 4; i++) apply_vec(i);

    idle_a();
    bus_a.start = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold%0d state", i), bus_a.state_o, 2);
    end
    bus_a.start = 0;
    tick();
    chk("release state", bus_a.state_o, 0);
    chk("release plot", bus_a.plot, 0);
    check_clear("clr_play", 3'd3, 0, 0, 1, 1);
    tick();
    chk("restart pulse end", bus_a.game_restart, 0);

    for (int i = 5; i <= 14; i++) apply_vec(i);
    check_clear("clr_over", 3'd5, 0, 1, 0, 0);
    for (int i = 15; i <= 19; i++) apply_vec(i);
    check_clear("clr_replay", 3'd3, 0, 0, 1, 1);
    tick();
    chk("replay pulse end", bus_a.game_restart, 0);

    // Reset landing on clear pixel 7 must abandon the sweep and restart at (0,0).
    resetn = 0;
    tick();
    resetn = 1;
    for (int i = 0; i < 7; i++) tick();
    chk("pre-abort x", bus_a.x_out, 2);
    resetn = 0;
    tick();
    chk("abort outputs", {bus_a.plot, bus_a.x_out, bus_a.y_out, bus_a.col_out,
        bus_a.draw_home, bus_a.game_en, bus_a.state_o}, 0);
    resetn = 1;
    tick();
    chk("restart pix0", {bus_a.plot, bus_a.col_out, bus_a.y_out, bus_a.x_out},
        {1'b1, 3'd5, 7'd0, 8'd0});

    chk("b rst outputs", {bus_b.plot, bus_b.x_out, bus_b.draw_home, bus_b.game_en}, 0);
    resetn_b = 1;
    tick();
    chk("b state", bus_b.state_o, 1);
    chk("b draw_home", bus_b.draw_home, 1);
    chk("b no clear plot", bus_b.plot, 0);
    bus_b.hs_done = 1;
    tick();
    bus_b.hs_done = 0;
    chk("b home", bus_b.state_o, 2);
    bus_b.start = 1;
    tick();
    bus_b.start = 0;
    tick();
    chk("b play", bus_b.state_o, 3);
    chk("b restart", bus_b.game_restart, 1);
    chk("b game_en", bus_b.game_en, 1);
    chk("b plot", bus_b.plot, 0);
    tick();
    chk("b restart end", bus_b.game_restart, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
